// File: rtl/alu_cmd_ctrl.sv
// Command-frame controller for a byte-serial ALU: collects operands and function,
// fires the ALU, waits (with a watchdog) for the result and sends it low byte first.
//   state    | meaning
//   IDLE     | waiting for a command byte (0xCC full frame, 0xDD function only)
//   GET_A    | next byte is operand A
//   GET_B    | next byte is operand B
//   GET_FUN  | next byte is the function code
//   ALU_RUN  | ALU_EN high for this single cycle
//   WAIT_RES | waiting for ALU_OUT_VALID, watchdog running
//   SEND_LO  | low result byte pending, held off by TX_BUSY
//   SEND_HI  | high result byte pending, held off by TX_BUSY
module alu_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int WD_CYCLES  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic [DATA_WIDTH-1:0]   ALU_A,
  output logic [DATA_WIDTH-1:0]   ALU_B,
  output logic [3:0]              ALU_FUN,
  output logic                    ALU_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VALID,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    TX_BUSY,
  output logic                    BUSY,
  output logic                    CMD_ERR
);

  localparam int WD_W = (WD_CYCLES < 2) ? 1 : $clog2(WD_CYCLES + 1);
  localparam logic [WD_W-1:0]       WD_LOAD = WD_W'(WD_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] CMD_AB  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);
  localparam logic [DATA_WIDTH-1:0] FUN_MAX = DATA_WIDTH'(8'h0E);

  typedef enum logic [2:0] {
    IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, WAIT_RES, SEND_LO, SEND_HI
  } state_t;

  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_alu_a;
  logic [DATA_WIDTH-1:0]   r_alu_b;
  logic [3:0]              r_alu_fun;
  logic                    r_alu_en;
  logic [2*DATA_WIDTH-1:0] r_result;
  logic [DATA_WIDTH-1:0]   r_tx_data;
  logic                    r_tx_vld;
  logic                    r_busy;
  logic                    r_cmd_err;
  logic [WD_W-1:0]         r_wd_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_fun <= '0;
      r_alu_en  <= 1'b0;
      r_result  <= '0;
      r_tx_data <= '0;
      r_tx_vld  <= 1'b0;
      r_busy    <= 1'b0;
      r_cmd_err <= 1'b0;
      r_wd_cnt  <= '0;
    end else begin
      r_alu_en  <= 1'b0;
      r_tx_vld  <= 1'b0;
      r_cmd_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_DATA == CMD_AB) begin
              r_state <= GET_A;
              r_busy  <= 1'b1;
            end else if (RX_P_DATA == CMD_FUN) begin
              r_state <= GET_FUN;
              r_busy  <= 1'b1;
            end else begin
              r_cmd_err <= 1'b1;
            end
          end
        end
        GET_A: begin
          if (RX_D_VLD) begin
            r_alu_a <= RX_P_DATA;
            r_state <= GET_B;
          end
        end
        GET_B: begin
          if (RX_D_VLD) begin
            r_alu_b <= RX_P_DATA;
            r_state <= GET_FUN;
          end
        end
        GET_FUN: begin
          if (RX_D_VLD) begin
            if (RX_P_DATA <= FUN_MAX) begin
              r_alu_fun <= RX_P_DATA[3:0];
              r_alu_en  <= 1'b1;
              r_state   <= ALU_RUN;
            end else begin
              r_cmd_err <= 1'b1;
              r_state   <= IDLE;
              r_busy    <= 1'b0;
            end
          end
        end
        ALU_RUN: begin
          r_cmd_err <= RX_D_VLD;
          r_wd_cnt  <= WD_LOAD;
          r_state   <= WAIT_RES;
        end
        WAIT_RES: begin
          r_cmd_err <= RX_D_VLD;
          if (ALU_OUT_VALID) begin
            r_result <= ALU_OUT;
            r_state  <= SEND_LO;
          end else if (r_wd_cnt == '0) begin
            // watchdog expiry: abandon the frame without sending anything
            r_cmd_err <= 1'b1;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
          end else begin
            r_wd_cnt <= r_wd_cnt - WD_W'(1);
          end
        end
        SEND_LO: begin
          r_cmd_err <= RX_D_VLD;
          if (!TX_BUSY) begin
            r_tx_data <= r_result[DATA_WIDTH-1:0];
            r_tx_vld  <= 1'b1;
            r_state   <= SEND_HI;
          end
        end
        SEND_HI: begin
          r_cmd_err <= RX_D_VLD;
          if (!TX_BUSY) begin
            r_tx_data <= r_result[2*DATA_WIDTH-1:DATA_WIDTH];
            r_tx_vld  <= 1'b1;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ALU_A     = r_alu_a;
  assign ALU_B     = r_alu_b;
  assign ALU_FUN   = r_alu_fun;
  assign ALU_EN    = r_alu_en;
  assign TX_P_DATA = r_tx_data;
  assign TX_D_VLD  = r_tx_vld;
  assign BUSY      = r_busy;
  assign CMD_ERR   = r_cmd_err;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl: directed timing sequences, a frame vector
// table and randomized frames checked against a frame-level reference model.
module tb_alu_cmd_ctrl;
  localparam int DW = 8;
  localparam int WD = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_P_DATA = 8'h00;
  logic        RX_D_VLD = 1'b0;
  logic [7:0]  ALU_A, ALU_B, TX_P_DATA;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN, TX_D_VLD, BUSY, CMD_ERR;
  logic [15:0] ALU_OUT = 16'h0000;
  logic        ALU_OUT_VALID = 1'b0;
  logic        TX_BUSY = 1'b0;

  alu_cmd_ctrl #(.DATA_WIDTH(DW), .WD_CYCLES(WD)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
    .BUSY(BUSY), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] f);
    logic [15:0] wa, wb;
    wa = {8'h00, a};
    wb = {8'h00, b};
    case (f)
      4'h0: return wa + wb;
      4'h1: return wa - wb;
      4'h2: return wa * wb;
      4'h3: return (b == 8'h00) ? 16'h0000 : wa / wb;
      4'h4: return wa & wb;
      4'h5: return wa | wb;
      4'h6: return {8'h00, ~(a & b)};
      4'h7: return {8'h00, ~(a | b)};
      4'h8: return wa ^ wb;
      4'h9: return {8'h00, ~(a ^ b)};
      4'hA: return {15'h0, a == b};
      4'hB: return {15'h0, a > b};
      4'hC: return {15'h0, a < b};
      4'hD: return wa >> 1;
      4'hE: return wa << 1;
      default: return 16'h0000;
    endcase
  endfunction

  // ALU stand-in: answers an ALU_EN pulse after alu_lat cycles with a one-cycle valid
  int   alu_lat = 1;
  bit   alu_respond = 1'b1;
  int   pend = 0;
  logic en_s;
  always @(posedge CLK) begin
    en_s = ALU_EN;
    #1;
    if (en_s && alu_respond) pend = alu_lat;
    ALU_OUT_VALID = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        ALU_OUT_VALID = 1'b1;
        ALU_OUT = alu_ref(ALU_A, ALU_B, ALU_FUN);
      end
    end
  end

  logic [19:0] en_q[$];
  logic [7:0]  tx_q[$];
  int          err_cnt = 0;
  bit          busy_seen = 1'b0;
  bit          err_prev = 1'b0;
  always @(negedge CLK) begin
    if (ALU_EN)   en_q.push_back({ALU_A, ALU_B, ALU_FUN});
    if (TX_D_VLD) tx_q.push_back(TX_P_DATA);
    if (BUSY)     busy_seen = 1'b1;
    if (CMD_ERR) begin
      err_cnt++;
      n_cmp++;
      if (err_prev) begin
        n_bad++;
        $display("FAIL cmd_err_width: CMD_ERR high for 2 cycles in a row, want 1-cycle pulse");
      end
    end
    err_prev = CMD_ERR;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  bit rand_busy = 1'b0;
  task automatic tick();
    @(posedge CLK);
    #1;
    if (rand_busy) TX_BUSY = ($urandom_range(0, 9) < 3);
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic clear_mon();
    en_q.delete();
    tx_q.delete();
    err_cnt   = 0;
    busy_seen = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while ((BUSY || TX_D_VLD) && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: BUSY still 1 after %0d cycles, want 0", nm, k);
    end
    tick();
    tick();
  endtask

  task automatic chk_frame(input string nm, input bit en, input logic [7:0] a,
                           input logic [7:0] b, input logic [3:0] f,
                           input logic [7:0] lo, input logic [7:0] hi, input int err);
    chk({nm, "_en_cnt"}, en_q.size(), en ? 1 : 0);
    if (en && en_q.size() > 0) chk({nm, "_abf"}, en_q[0], {a, b, f});
    chk({nm, "_tx_cnt"}, tx_q.size(), en ? 2 : 0);
    if (en && tx_q.size() > 1) begin
      chk({nm, "_tx_lo"}, tx_q[0], lo);
      chk({nm, "_tx_hi"}, tx_q[1], hi);
    end
    chk({nm, "_err_cnt"}, err_cnt, err);
  endtask

  typedef struct {
    logic [31:0] bytes;
    int          nb;
    bit          en;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  f;
    logic [7:0]  lo;
    logic [7:0]  hi;
    int          err;
    bit          busy;
  } vec_t;
  vec_t vt[8];

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [19:0] exp_en[$];
    logic [7:0]  exp_tx[$];
    int          exp_err;
    logic [7:0]  a_m, b_m, ra, rb, rf, jb;
    logic [15:0] r;
    int          kind, errs;

    vt[0] = '{32'hCC102002, 4, 1'b1, 8'h10, 8'h20, 4'h2, 8'h00, 8'h02, 0, 1'b1};
    vt[1] = '{32'hDD000000, 2, 1'b1, 8'h10, 8'h20, 4'h0, 8'h30, 8'h00, 0, 1'b1};
    vt[2] = '{32'h55000000, 1, 1'b0, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 1, 1'b0};
    vt[3] = '{32'hCC01010F, 4, 1'b0, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 1, 1'b1};
    vt[4] = '{32'hDD0E0000, 2, 1'b1, 8'h01, 8'h01, 4'hE, 8'h02, 8'h00, 0, 1'b1};
    vt[5] = '{32'hCCFFFF02, 4, 1'b1, 8'hFF, 8'hFF, 4'h2, 8'h01, 8'hFE, 0, 1'b1};
    vt[6] = '{32'hCC070901, 4, 1'b1, 8'h07, 8'h09, 4'h1, 8'hFE, 8'hFF, 0, 1'b1};
    vt[7] = '{32'hDD0A0000, 2, 1'b1, 8'h07, 8'h09, 4'hA, 8'h00, 8'h00, 0, 1'b1};

    // reset state
    repeat (3) tick();
    chk("rst_outputs", {ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, BUSY, CMD_ERR}, 0);
    RST = 1'b0;
    tick();

    // nominal latency: FUN accepted at edge N, strobes launched by edges N+3 and N+4
    clear_mon();
    send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
    chk("lat_en_n1", ALU_EN, 1);
    chk("lat_abf", {ALU_A, ALU_B, ALU_FUN}, {8'h05, 8'h03, 4'h0});
    chk("lat_busy", BUSY, 1);
    tick();
    chk("lat_en_off", {ALU_EN, TX_D_VLD}, 0);
    tick();
    chk("lat_no_tx_n2", TX_D_VLD, 0);
    tick();
    chk("lat_tx_lo", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h08});
    tick();
    chk("lat_tx_hi", {TX_D_VLD, TX_P_DATA, BUSY}, {1'b1, 8'h00, 1'b0});
    tick();
    chk("lat_tx_done", {TX_D_VLD, ALU_EN}, 0);
    tick();
    chk_frame("lat", 1'b1, 8'h05, 8'h03, 4'h0, 8'h08, 8'h00, 0);

    for (int i = 0; i < 8; i++) begin
      clear_mon();
      for (int j = 0; j < vt[i].nb; j++) send_byte(vt[i].bytes[31-8*j -: 8]);
      wait_idle($sformatf("vec%0d", i));
      chk_frame($sformatf("vec%0d", i), vt[i].en, vt[i].a, vt[i].b, vt[i].f,
                vt[i].lo, vt[i].hi, vt[i].err);
      chk($sformatf("vec%0d_busy_seen", i), busy_seen, vt[i].busy);
    end

    // transmit back-pressure
    clear_mon();
    TX_BUSY = 1'b1;
    send_byte(8'hCC); send_byte(8'h03); send_byte(8'h04); send_byte(8'h00);
    repeat (8) tick();
    chk("stall_no_vld", tx_q.size(), 0);
    chk("stall_busy", BUSY, 1);
    TX_BUSY = 1'b0;
    wait_idle("stall");
    chk_frame("stall", 1'b1, 8'h03, 8'h04, 4'h0, 8'h07, 8'h00, 0);

    // watchdog: no ALU answer
    clear_mon();
    alu_respond = 1'b0;
    send_byte(8'hCC); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
    errs = 0;
    repeat (WD) begin
      tick();
      if (CMD_ERR) errs++;
    end
    chk("wd_early_err", errs, 0);
    tick();
    chk("wd_err", CMD_ERR, 1);
    chk("wd_busy", BUSY, 0);
    tick();
    chk("wd_err_drop", CMD_ERR, 0);
    alu_respond = 1'b1;
    repeat (3) tick();
    chk("wd_no_tx", tx_q.size(), 0);
    chk("wd_err_cnt", err_cnt, 1);

    // stray byte while waiting for a slow result
    clear_mon();
    alu_lat = 3;
    send_byte(8'hCC); send_byte(8'h04); send_byte(8'h05); send_byte(8'h00);
    tick();
    send_byte(8'h77);
    chk("stray_err", {CMD_ERR, BUSY}, 2'b11);
    wait_idle("stray");
    chk_frame("stray", 1'b1, 8'h04, 8'h05, 4'h0, 8'h09, 8'h00, 1);
    alu_lat = 1;

    // reset mid-frame, then reuse of cleared operands
    clear_mon();
    send_byte(8'hCC); send_byte(8'h07);
    RST = 1'b1;
    tick();
    chk("midrst_outputs", {ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, BUSY, CMD_ERR}, 0);
    RST = 1'b0;
    tick();
    send_byte(8'hDD); send_byte(8'h00);
    wait_idle("postrst_dd");
    chk_frame("postrst_dd", 1'b1, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 0);
    clear_mon();
    send_byte(8'hCC); send_byte(8'h02); send_byte(8'h02); send_byte(8'h0A);
    wait_idle("postrst_eq");
    chk_frame("postrst_eq", 1'b1, 8'h02, 8'h02, 4'hA, 8'h01, 8'h00, 0);

    // reset while a send is stalled
    clear_mon();
    TX_BUSY = 1'b1;
    send_byte(8'hCC); send_byte(8'h03); send_byte(8'h04); send_byte(8'h00);
    repeat (4) tick();
    RST = 1'b1;
    tick();
    chk("sendrst_state", {BUSY, TX_D_VLD}, 0);
    RST = 1'b0;
    TX_BUSY = 1'b0;
    repeat (6) tick();
    chk("sendrst_no_tx", tx_q.size(), 0);
    chk("sendrst_idle", BUSY, 0);

    // randomized frames against the frame-level model (operands cleared by reset above)
    clear_mon();
    a_m = 8'h00;
    b_m = 8'h00;
    exp_err = 0;
    rand_busy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 5);
      alu_lat = $urandom_range(1, 3);
      if (kind == 0) begin
        jb = 8'($urandom_range(0, 255));
        if (jb == 8'hCC || jb == 8'hDD) jb = 8'h5A;
        send_byte(jb);
        exp_err++;
      end else begin
        rf = 8'($urandom_range(0, 20));
        if (kind <= 3) begin
          ra = 8'($urandom_range(0, 255));
          rb = 8'($urandom_range(0, 255));
          send_byte(8'hCC);
          repeat ($urandom_range(0, 2)) tick();
          send_byte(ra);
          repeat ($urandom_range(0, 2)) tick();
          send_byte(rb);
          repeat ($urandom_range(0, 2)) tick();
          a_m = ra;
          b_m = rb;
        end else begin
          send_byte(8'hDD);
          repeat ($urandom_range(0, 2)) tick();
        end
        send_byte(rf);
        if (rf > 8'h0E) begin
          exp_err++;
        end else begin
          exp_en.push_back({a_m, b_m, rf[3:0]});
          r = alu_ref(a_m, b_m, rf[3:0]);
          exp_tx.push_back(r[7:0]);
          exp_tx.push_back(r[15:8]);
        end
      end
      wait_idle("rnd");
    end
    rand_busy = 1'b0;
    TX_BUSY = 1'b0;
    alu_lat = 1;
    tick();
    chk("rnd_en_cnt", en_q.size(), exp_en.size());
    for (int i = 0; i < exp_en.size() && i < en_q.size(); i++)
      chk($sformatf("rnd_abf%0d", i), en_q[i], exp_en[i]);
    chk("rnd_tx_cnt", tx_q.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
      chk($sformatf("rnd_tx%0d", i), tx_q[i], exp_tx[i]);
    chk("rnd_err_cnt", err_cnt, exp_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
